// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the two-master Wishbone arbiter.
package wb_arbiter_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_D = 2'd1,
        ST_GNT_I = 2'd2,
        ST_ERR   = 2'd3
    } arb_state_e;

    // All byte lanes enabled
    localparam logic [3:0] WB_SEL_ALL = 4'b1111;

endpackage

// File: rtl/wb_arbiter.sv
// Two-master (data / instruction) Wishbone arbiter onto a single slave.
// Data master has priority; the instruction master is forced through after
// STARVE_LIMIT consecutive data grants taken while it was waiting. A grant
// that sees no slave ack for TIMEOUT_CYCLES cycles is aborted with a
// one-cycle err pulse to the owning master.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_data_i,
    input  logic        d_we_i,
    input  logic [3:0]  d_sel_i,
    input  logic        d_stb_i,
    input  logic        d_cyc_i,
    output logic [31:0] d_data_o,
    output logic        d_ack_o,
    output logic        d_err_o,

    input  logic [31:0] i_addr_i,
    input  logic [31:0] i_data_i,
    input  logic        i_we_i,
    input  logic [3:0]  i_sel_i,
    input  logic        i_stb_i,
    input  logic        i_cyc_i,
    output logic [31:0] i_data_o,
    output logic        i_ack_o,
    output logic        i_err_o,

    output logic [31:0] s_addr_o,
    output logic [31:0] s_data_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic        s_stb_o,
    output logic        s_cyc_o,
    input  logic [31:0] s_data_i,
    input  logic        s_ack_i
);

    // Counter widths hold their terminal values without wrapping
    localparam int TO_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int SV_W = (STARVE_LIMIT < 1)   ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SV_W-1:0] SV_MAX  = SV_W'(STARVE_LIMIT);

    arb_state_e      state_q, state_d;
    logic [SV_W-1:0] starve_q, starve_d;
    logic [TO_W-1:0] to_q, to_d;
    logic            err_i_q, err_i_d;   // ERR belongs to the instruction master

    logic d_req, i_req, own_cyc;

    assign d_req = d_cyc_i & d_stb_i;
    assign i_req = i_cyc_i & i_stb_i;

    // State and counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            starve_q <= '0;
            to_q     <= '0;
            err_i_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            to_q     <= to_d;
            err_i_q  <= err_i_d;
        end
    end

    // Arbitration, timeout and starvation bookkeeping
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        to_d     = to_q;
        err_i_d  = err_i_q;
        own_cyc  = (state_q == ST_GNT_I) ? i_cyc_i : d_cyc_i;
        case (state_q)
            ST_IDLE: begin
                to_d = '0;
                if (d_req && i_req && (starve_q == SV_MAX)) begin
                    state_d  = ST_GNT_I;
                    starve_d = '0;
                end else if (d_req) begin
                    state_d = ST_GNT_D;
                    if (i_req && (starve_q != SV_MAX))
                        starve_d = starve_q + SV_W'(1);
                end else if (i_req) begin
                    state_d  = ST_GNT_I;
                    starve_d = '0;
                end
            end
            ST_GNT_D, ST_GNT_I: begin
                // Master abandoning the cycle beats any late ack; ack beats timeout
                if (!own_cyc || s_ack_i) begin
                    state_d = ST_IDLE;
                    to_d    = '0;
                end else if (to_q == TO_LAST) begin
                    state_d = ST_ERR;
                    to_d    = '0;
                    err_i_d = (state_q == ST_GNT_I);
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Slave-side mux: follows the granted master, quiet otherwise
    always_comb begin
        s_addr_o = '0;
        s_data_o = '0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_stb_o  = 1'b0;
        s_cyc_o  = 1'b0;
        case (state_q)
            ST_GNT_D: begin
                s_addr_o = d_addr_i;
                s_data_o = d_data_i;
                s_we_o   = d_we_i;
                s_sel_o  = d_sel_i;
                s_stb_o  = d_stb_i;
                s_cyc_o  = d_cyc_i;
            end
            ST_GNT_I: begin
                s_addr_o = i_addr_i;
                s_data_o = i_data_i;
                s_we_o   = i_we_i;
                s_sel_o  = i_sel_i;
                s_stb_o  = i_stb_i;
                s_cyc_o  = i_cyc_i;
            end
            default: ;
        endcase
    end

    assign d_data_o = s_data_i;
    assign i_data_o = s_data_i;
    assign d_ack_o  = (state_q == ST_GNT_D) & s_ack_i;
    assign i_ack_o  = (state_q == ST_GNT_I) & s_ack_i;
    assign d_err_o  = (state_q == ST_ERR) & ~err_i_q;
    assign i_err_o  = (state_q == ST_ERR) &  err_i_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: stimulus pushes expected grants and
// responses; negedge monitors pop and compare whenever the DUT presents one.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int TO_CYC = 8;
    localparam int STARVE = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] d_addr_i = '0, d_data_i = '0, i_addr_i = '0, i_data_i = '0;
    logic        d_we_i = 1'b0, d_stb_i = 1'b0, d_cyc_i = 1'b0;
    logic        i_we_i = 1'b0, i_stb_i = 1'b0, i_cyc_i = 1'b0;
    logic [3:0]  d_sel_i = '0, i_sel_i = '0;
    logic [31:0] d_data_o, i_data_o, s_addr_o, s_data_o;
    logic        d_ack_o, d_err_o, i_ack_o, i_err_o;
    logic        s_we_o, s_stb_o, s_cyc_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_data_i = '0;
    logic        s_ack_i = 1'b0;

    wb_arbiter #(.TIMEOUT_CYCLES(TO_CYC), .STARVE_LIMIT(STARVE)) dut (
        .clk(clk), .rst(rst),
        .d_addr_i(d_addr_i), .d_data_i(d_data_i), .d_we_i(d_we_i), .d_sel_i(d_sel_i),
        .d_stb_i(d_stb_i), .d_cyc_i(d_cyc_i), .d_data_o(d_data_o), .d_ack_o(d_ack_o),
        .d_err_o(d_err_o),
        .i_addr_i(i_addr_i), .i_data_i(i_data_i), .i_we_i(i_we_i), .i_sel_i(i_sel_i),
        .i_stb_i(i_stb_i), .i_cyc_i(i_cyc_i), .i_data_o(i_data_o), .i_ack_o(i_ack_o),
        .i_err_o(i_err_o),
        .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_data_i(s_data_i), .s_ack_i(s_ack_i)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [31:0] addr; logic we; } grant_t;
    typedef struct packed { logic d_ack; logic i_ack; logic d_err; logic i_err; logic [31:0] data; } resp_t;

    grant_t exp_grant[$];
    resp_t  exp_resp[$];
    int     checks = 0;
    int     passed = 0;
    int     ack_delay = -1;   // -1: slave never acks
    int     wait_cnt = 0;
    logic   cyc_prev = 1'b0;

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        return a ^ 32'hA5A5_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic push_grant(input logic [31:0] a, input logic we);
        grant_t g;
        g.addr = a; g.we = we;
        exp_grant.push_back(g);
    endtask

    task automatic push_resp(input logic da, input logic ia, input logic de, input logic ie,
                             input logic [31:0] data);
        resp_t r;
        r.d_ack = da; r.i_ack = ia; r.d_err = de; r.i_err = ie; r.data = data;
        exp_resp.push_back(r);
    endtask

    // Slave model: acks after ack_delay granted cycles, data derived from address
    always @(posedge clk) begin
        #1;
        if (s_cyc_o && s_stb_o) begin
            if (ack_delay >= 0 && wait_cnt == ack_delay) begin
                s_ack_i  = 1'b1;
                s_data_i = rdata_of(s_addr_o);
            end else begin
                s_ack_i  = 1'b0;
                s_data_i = '0;
            end
            wait_cnt++;
        end else begin
            s_ack_i  = 1'b0;
            s_data_i = '0;
            wait_cnt = 0;
        end
    end

    // Grant monitor: each rising s_cyc_o must match the next expected grant
    always @(negedge clk) begin
        grant_t g;
        if (s_cyc_o && !cyc_prev) begin
            if (exp_grant.size() == 0) begin
                checks++;
                $display("FAIL unexpected_grant: got addr %h, none expected", s_addr_o);
            end else begin
                g = exp_grant.pop_front();
                check("grant_addr", s_addr_o, g.addr);
                check("grant_we", 32'(s_we_o), 32'(g.we));
            end
        end
        cyc_prev <= s_cyc_o;
    end

    // Response monitor: every ack/err pulse must match the next expected response
    always @(negedge clk) begin
        resp_t r;
        if (d_ack_o || i_ack_o || d_err_o || i_err_o) begin
            if (exp_resp.size() == 0) begin
                checks++;
                $display("FAIL unexpected_resp: got flags %b, none expected",
                         {d_ack_o, i_ack_o, d_err_o, i_err_o});
            end else begin
                r = exp_resp.pop_front();
                check("resp_flags", 32'({d_ack_o, i_ack_o, d_err_o, i_err_o}),
                      32'({r.d_ack, r.i_ack, r.d_err, r.i_err}));
                if (r.d_ack) check("resp_d_data", d_data_o, r.data);
                if (r.i_ack) check("resp_i_data", i_data_o, r.data);
            end
        end
    end

    // Count negedges (total and with s_cyc_o high) up to and including a response
    task automatic run_until_resp(input string name, input int maxc, output int total, output int gcnt);
        total = 0;
        gcnt  = 0;
        forever begin
            @(negedge clk);
            total++;
            if (s_cyc_o) gcnt++;
            if (d_ack_o || i_ack_o || d_err_o || i_err_o) break;
            if (total >= maxc) begin
                checks++;
                $display("FAIL %s: no response within %0d cycles", name, maxc);
                break;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, checks);
        $fatal(1);
    end

    initial begin
        int total, gcnt, n, acks;

        // Reset
        #2 rst = 1'b0;
        #1 check("reset_outputs", 32'({s_cyc_o, s_stb_o, s_we_o, s_sel_o, d_ack_o, i_ack_o, d_err_o, i_err_o}), 32'd0);
        check("reset_addr", s_addr_o, 32'd0);
        step(); step();
        rst = 1'b1;
        step();

        // Single data read, slave acks in the 4th granted cycle
        ack_delay = 3;
        d_addr_i = 32'h8000_0010; d_we_i = 1'b0; d_sel_i = WB_SEL_ALL;
        d_cyc_i = 1'b1; d_stb_i = 1'b1;
        push_grant(32'h8000_0010, 1'b0);
        push_resp(1'b1, 1'b0, 1'b0, 1'b0, rdata_of(32'h8000_0010));
        run_until_resp("t1_ack", 20, total, gcnt);
        check("t1_cycles_to_ack", 32'(total), 32'd5);
        check("t1_granted_cycles", 32'(gcnt), 32'd4);
        step();
        d_cyc_i = 1'b0; d_stb_i = 1'b0;
        @(negedge clk);
        check("t1_idle_after_ack", 32'(s_cyc_o), 32'd0);

        // Instruction timeout: 8 granted cycles, one-cycle err, then idle
        ack_delay = -1;
        step();
        i_addr_i = 32'h0000_1000; i_we_i = 1'b0; i_sel_i = WB_SEL_ALL;
        i_cyc_i = 1'b1; i_stb_i = 1'b1;
        push_grant(32'h0000_1000, 1'b0);
        push_resp(1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
        run_until_resp("t2_err", 40, total, gcnt);
        check("t2_granted_cycles", 32'(gcnt), 32'(TO_CYC));
        check("t2_cyc_low_in_err", 32'(s_cyc_o), 32'd0);
        step();
        i_cyc_i = 1'b0; i_stb_i = 1'b0;
        @(negedge clk);
        check("t2_err_one_cycle", 32'(i_err_o), 32'd0);
        check("t2_idle_after_err", 32'(s_cyc_o), 32'd0);

        // Ack in the same cycle the timeout would fire: ack wins
        ack_delay = TO_CYC - 1;
        step();
        i_addr_i = 32'h0000_2000; i_cyc_i = 1'b1; i_stb_i = 1'b1;
        push_grant(32'h0000_2000, 1'b0);
        push_resp(1'b0, 1'b1, 1'b0, 1'b0, rdata_of(32'h0000_2000));
        run_until_resp("t3_ack", 40, total, gcnt);
        check("t3_granted_cycles", 32'(gcnt), 32'(TO_CYC));
        step();
        i_cyc_i = 1'b0; i_stb_i = 1'b0;
        @(negedge clk);
        check("t3_no_err_after", 32'({i_err_o, d_err_o, s_cyc_o}), 32'd0);

        // Reset mid data write with instruction pending (starve count becomes 1)
        ack_delay = -1;
        step();
        d_addr_i = 32'h0000_3000; d_data_i = 32'h1234_5678; d_we_i = 1'b1;
        d_cyc_i = 1'b1; d_stb_i = 1'b1;
        i_addr_i = 32'h0000_4000; i_cyc_i = 1'b1; i_stb_i = 1'b1;
        push_grant(32'h0000_3000, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("t4_granted", 32'(s_cyc_o), 32'd1);
        check("t4_wdata", s_data_o, 32'h1234_5678);
        #2 rst = 1'b0;
        #1 check("t4_async_reset_ctrl", 32'({s_cyc_o, s_stb_o, s_we_o, s_sel_o}), 32'd0);
        check("t4_async_reset_addr", s_addr_o, 32'd0);
        check("t4_async_reset_data", s_data_o, 32'd0);
        d_cyc_i = 1'b0; d_stb_i = 1'b0; d_we_i = 1'b0;
        i_cyc_i = 1'b0; i_stb_i = 1'b0;
        step();
        rst = 1'b1;
        @(negedge clk);
        check("t4_idle_after_release", 32'(s_cyc_o), 32'd0);

        // Both masters always requesting: D,D,D,D,I repeating
        ack_delay = 1;
        step();
        d_addr_i = 32'h0000_5000; d_cyc_i = 1'b1; d_stb_i = 1'b1;
        i_addr_i = 32'h0000_6000; i_cyc_i = 1'b1; i_stb_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if ((k % 5) == 4) begin
                push_grant(32'h0000_6000, 1'b0);
                push_resp(1'b0, 1'b1, 1'b0, 1'b0, rdata_of(32'h0000_6000));
            end else begin
                push_grant(32'h0000_5000, 1'b0);
                push_resp(1'b1, 1'b0, 1'b0, 1'b0, rdata_of(32'h0000_5000));
            end
        end
        n = 0; acks = 0;
        while (acks < 10 && n < 200) begin
            @(negedge clk);
            n++;
            if (d_ack_o || i_ack_o) acks++;
        end
        check("t5_ack_count", 32'(acks), 32'd10);
        step();
        d_cyc_i = 1'b0; d_stb_i = 1'b0; i_cyc_i = 1'b0; i_stb_i = 1'b0;

        // Data write abandoned 2 cycles into grant; instruction granted next
        ack_delay = -1;
        step();
        d_addr_i = 32'h0000_7000; d_data_i = 32'hCAFE_F00D; d_we_i = 1'b1; d_sel_i = 4'b0011;
        d_cyc_i = 1'b1; d_stb_i = 1'b1;
        i_addr_i = 32'h0000_7100; i_cyc_i = 1'b1; i_stb_i = 1'b1;
        push_grant(32'h0000_7000, 1'b1);
        push_grant(32'h0000_7100, 1'b0);
        push_resp(1'b0, 1'b1, 1'b0, 1'b0, rdata_of(32'h0000_7100));
        step();
        check("t6_sel", 32'(s_sel_o), 32'h3);
        check("t6_wdata", s_data_o, 32'hCAFE_F00D);
        step();
        step();
        d_cyc_i = 1'b0;
        ack_delay = 1;
        #1 check("t6_cyc_drop_same_cycle", 32'(s_cyc_o), 32'd0);
        run_until_resp("t6_i_ack", 20, total, gcnt);
        check("t6_i_granted_cycles", 32'(gcnt), 32'd2);
        step();
        d_stb_i = 1'b0; d_we_i = 1'b0; i_cyc_i = 1'b0; i_stb_i = 1'b0;
        @(negedge clk);
        @(negedge clk);

        check("grant_queue_empty", 32'(exp_grant.size()), 32'd0);
        check("resp_queue_empty", 32'(exp_resp.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: granted cycles without slave ack before the bus is aborted.
REQ-002 Parameter STARVE_LIMIT, default 4: consecutive data grants tolerated while the instruction master waits.
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 d_addr_i/d_data_i  in  32 each; d_we_i  in  1; d_sel_i  in  4; d_stb_i/d_cyc_i  in  1 each: data-master request.
REQ-006 d_data_o  out  32; d_ack_o/d_err_o  out  1 each: data-master response.
REQ-007 i_addr_i/i_data_i  in  32 each; i_we_i  in  1; i_sel_i  in  4; i_stb_i/i_cyc_i  in  1 each: instruction-master request.
REQ-008 i_data_o  out  32; i_ack_o/i_err_o  out  1 each: instruction-master response.
REQ-009 s_addr_o/s_data_o  out  32 each; s_we_o  out  1; s_sel_o  out  4; s_stb_o/s_cyc_o  out  1 each: shared slave request.
REQ-010 s_data_i  in  32; s_ack_i  in  1: shared slave response.

Function
REQ-011 States: IDLE, GNT_D, GNT_I, ERR, held in a registered state variable.
REQ-012 IDLE: d_cyc_i&d_stb_i -> GNT_D; else i_cyc_i&i_stb_i -> GNT_I; else stay.
REQ-013 Starvation override: from IDLE, if both masters request and starve_cnt==STARVE_LIMIT, -> GNT_I.
REQ-014 starve_cnt: +1 on each IDLE->GNT_D while instruction request is pending; cleared on any entry to GNT_I; saturates at STARVE_LIMIT.
REQ-015 Grant latency: master request to s_cyc_o high is exactly one clock.
REQ-016 In GNT_x: s_addr/data/we/sel/stb/cyc_o follow master x combinationally; in IDLE/ERR, s_cyc_o=s_stb_o=s_we_o=0 and s_sel_o=0.
REQ-017 x_data_o = s_data_i for both masters; x_ack_o = s_ack_i only in GNT_x, otherwise 0.
REQ-018 GNT_x with s_ack_i=1 -> IDLE; arbitration re-runs in the following cycle (one idle bus cycle between transfers).
REQ-019 GNT_x with master x dropping cyc before ack -> IDLE, clearing the timeout counter; the slave sees cyc low in that same cycle.
REQ-020 Timeout counter: cleared on entry to GNT_x; +1 per GNT_x cycle without ack; when it reaches TIMEOUT_CYCLES-1 without ack -> ERR.
REQ-021 ERR lasts exactly one cycle: x_err_o=1 for the aborted master only, all acks 0 -> IDLE.
REQ-022 Ack and timeout in the same cycle: ack wins, no err is asserted.
REQ-023 A master holding cyc after err is re-arbitrated normally from IDLE.
REQ-024 Counter widths are sized by $clog2 of the parameters; no wrap-around is permitted.

Reset
REQ-025 rst low: state=IDLE, starve_cnt=0, timeout counter=0, immediately and without waiting for clk.
REQ-026 During reset, all s_*_o, acks and errs are 0; reset mid-transfer drops s_cyc_o at once.
REQ-027 Reset release takes effect on the first clk edge with rst high.

Structure
REQ-028 State encodings and the WB_SEL_ALL constant (4'b1111) belong in the shared defines package.
REQ-029 The block is a single flat module; no sub-module is instantiated.

Verification
REQ-030 Data read only, addr 0x8000_0010, slave ack 3 cycles later -> s_cyc_o high 1 cycle after request; d_ack_o pulses once; i_ack_o stays 0.
REQ-031 Both masters request each cycle, ack after 1 cycle, STARVE_LIMIT=4 -> grant order D,D,D,D,I repeating.
REQ-032 Instruction master requests, slave never acks, TIMEOUT_CYCLES=8 -> i_err_o pulses for exactly one cycle; s_cyc_o low during ERR; IDLE next.
REQ-033 Data write, d_cyc_i dropped 2 cycles into the grant -> s_cyc_o low the same cycle; no ack or err; an instruction request is granted next.
REQ-034 rst asserted low mid-GNT_D -> all s_*_o are 0 asynchronously; after release, state is IDLE and counters are 0.
REQ-035 s_ack_i asserted in the cycle the timeout expires -> ack delivered, no err, IDLE next.
